// File: rtl/imem_pkg.sv
// Shared constants and FSM encoding for the writable instruction memory.
package imem_pkg;
  localparam logic [31:0] NOP_INSN = 32'h0000_0033;
  localparam int ERR_MIS = 0;
  localparam int ERR_OOR = 1;
  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} fsm_e;
endpackage

// File: rtl/imem_fetch_if.sv
// Fetch request/response, redirect and program-load signals between fetch and imem.
interface imem_fetch_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_pc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_ins;
  logic [XLEN-1:0]   rsp_pc;
  logic [1:0]        rsp_err;
  logic              flush;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [XLEN-1:0]   prog_data;
  logic              init_done;

  modport master (
    output req_valid, req_pc, rsp_ready, flush, prog_we, prog_addr, prog_data,
    input  req_ready, rsp_valid, rsp_ins, rsp_pc, rsp_err, init_done
  );
  modport slave (
    input  req_valid, req_pc, rsp_ready, flush, prog_we, prog_addr, prog_data,
    output req_ready, rsp_valid, rsp_ins, rsp_pc, rsp_err, init_done
  );
endinterface

// File: rtl/imem_ram.sv
// DEPTH x XLEN storage, one write port and one registered read port (read-first).
module imem_ram #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [XLEN-1:0]   o_rdata
);
  logic [XLEN-1:0] r_mem [DEPTH];

  // Read enable doubles as the hold: o_rdata only moves on an accepted fetch.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/imem_fetch.sv
// Writable instruction memory with ready/valid fetch, clear-to-NOP init,
// flush on redirect and misaligned/out-of-range error tagging.
module imem_fetch #(
  parameter int              XLEN           = 32,
  parameter int              DEPTH          = 256,
  parameter logic [XLEN-1:0] NOP_INSN       = XLEN'(imem_pkg::NOP_INSN),
  parameter bit              CLEAR_ON_RESET = 1'b1
) (
  input logic         clk,
  input logic         rst,
  imem_fetch_if.slave bus
);
  import imem_pkg::*;

  localparam int         ADDR_W  = $clog2(DEPTH);
  localparam logic [0:0] ST_INIT = INIT;
  localparam logic [0:0] ST_RUN  = RUN;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_rsp_valid;
  logic              r_use_nop;
  logic [XLEN-1:0]   r_rsp_pc;
  logic [1:0]        r_rsp_err;

  logic              w_run;
  logic              w_req_ready;
  logic              w_accept;
  logic [1:0]        w_err;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_rdata;

  assign w_run       = (r_state == ST_RUN);
  assign w_req_ready = w_run && !bus.flush && (!r_rsp_valid || bus.rsp_ready);
  assign w_accept    = bus.req_valid && w_req_ready;

  assign w_err[ERR_MIS] = (bus.req_pc[1:0] != 2'b00);
  assign w_err[ERR_OOR] = (bus.req_pc[XLEN-1:ADDR_W+2] != '0);

  // The clear sequence owns the write port during INIT; program loads only in RUN.
  assign w_we    = !rst && (w_run ? bus.prog_we : 1'b1);
  assign w_waddr = w_run ? bus.prog_addr : r_clr_cnt;
  assign w_wdata = w_run ? bus.prog_data : NOP_INSN;

  imem_ram #(
    .XLEN   (XLEN),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_accept),
    .i_raddr (bus.req_pc[ADDR_W+1:2]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      r_clr_cnt   <= '0;
      r_rsp_valid <= 1'b0;
      r_use_nop   <= 1'b1;
      r_rsp_pc    <= '0;
      r_rsp_err   <= '0;
    end else if (!w_run) begin
      r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
      if (r_clr_cnt == ADDR_W'(DEPTH - 1)) r_state <= ST_RUN;
    end else if (bus.flush) begin
      r_rsp_valid <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_use_nop   <= |w_err;
      r_rsp_pc    <= bus.req_pc;
      r_rsp_err   <= w_err;
    end else if (bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Errored fetches (and the reset state) present NOP instead of RAM data.
  assign bus.rsp_ins   = r_use_nop ? NOP_INSN : w_rdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_pc    = r_rsp_pc;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.req_ready = w_req_ready;
  assign bus.init_done = w_run;
endmodule

// File: tb/tb_imem_fetch.sv
// Scenario tasks with a response scoreboard and a reference memory model.
module tb_imem_fetch;
  import imem_pkg::*;

  localparam int XLEN = 32;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [1:0]  err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_fetch_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus();

  imem_fetch #(
    .XLEN           (XLEN),
    .DEPTH          (DEPTH),
    .NOP_INSN       (NOP_INSN),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  rsp_t exp_q[$];
  logic [31:0] mem_m [DEPTH];

  function automatic rsp_t model(input logic [31:0] pc);
    rsp_t r;
    r.pc = pc;
    r.err[0] = (pc[1:0] != 2'b00);
    r.err[1] = (pc[31:ADDR_W+2] != '0);
    r.ins = (r.err != 2'b00) ? NOP_INSN : mem_m[pc[ADDR_W+1:2]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_pc = '0; bus.rsp_ready = 1'b0; bus.flush = 1'b0;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    tick(); tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_ins !== NOP_INSN) begin errors++; $display("FAIL reset_rsp_ins got %h want %h", bus.rsp_ins, NOP_INSN); end
    checks++; if (bus.rsp_pc !== 32'h0) begin errors++; $display("FAIL reset_rsp_pc got %h want 0", bus.rsp_pc); end
    checks++; if (bus.rsp_err !== 2'b00) begin errors++; $display("FAIL reset_rsp_err got %b want 00", bus.rsp_err); end
    checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %0b want 0", bus.init_done); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %0b want 0", bus.req_ready); end
  endtask

  task automatic test_init();
    int n;
    logic bad;
    rsp_t e;
    bus.req_valid = 1'b1; bus.req_pc = 32'h0;
    rst = 1'b0;
    repeat (5) tick();
    checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL init_early got %0b want 0", bus.init_done); end
    // Reset mid-clear: count must restart so the full 16 cycles are needed again.
    rst = 1'b1; tick(); rst = 1'b0;
    n = 0; bad = 1'b0;
    while (bus.init_done !== 1'b1 && n < 40) begin
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) bad = 1'b1;
      tick(); n++;
    end
    bus.req_valid = 1'b0;
    checks++; if (n != DEPTH) begin errors++; $display("FAIL init_cycles got %0d want %0d", n, DEPTH); end
    checks++; if (bad) begin errors++; $display("FAIL init_ready_low got ready/valid high want 0"); end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP_INSN;
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_pc = 32'h0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL init_fetch_ready got %0b want 1", bus.req_ready); end
    exp_q.push_back(model(32'h0));
    tick(); bus.req_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_ins !== 32'h0000_0033 || bus.rsp_err !== 2'b00 || bus.rsp_pc !== e.pc) begin
      errors++; $display("FAIL init_fetch0 got v=%0b ins=%h err=%b want v=1 ins=00000033 err=00", bus.rsp_valid, bus.rsp_ins, bus.rsp_err);
    end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL init_retire got %0b want 0", bus.rsp_valid); end
  endtask

  task automatic test_load_fetch();
    logic [31:0] d [3] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
    rsp_t e;
    bus.prog_we = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.prog_addr = ADDR_W'(i); bus.prog_data = d[i-1];
      tick();
      mem_m[i] = d[i-1];
    end
    bus.prog_we = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.req_valid = 1'b1; bus.req_pc = 32'(4 * i);
      #1;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL load_ready%0d got %0b want 1", i, bus.req_ready); end
      exp_q.push_back(model(bus.req_pc));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_ins !== d[i-1] || bus.rsp_pc !== e.pc || bus.rsp_err !== 2'b00) begin
        errors++; $display("FAIL load_rsp%0d got v=%0b ins=%h pc=%h want v=1 ins=%h pc=%h", i, bus.rsp_valid, bus.rsp_ins, bus.rsp_pc, d[i-1], e.pc);
      end
    end
    bus.req_valid = 1'b0;
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL load_drain got %0b want 0", bus.rsp_valid); end
  endtask

  task automatic test_errors();
    logic [31:0] pcs [3] = '{32'h6, 32'h40, 32'h42};
    logic [1:0]  errs [3] = '{2'b01, 2'b10, 2'b11};
    rsp_t e;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1; bus.req_pc = pcs[i];
      #1;
      exp_q.push_back(model(pcs[i]));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== errs[i] || bus.rsp_ins !== NOP_INSN || bus.rsp_pc !== pcs[i] || e.err !== errs[i]) begin
        errors++; $display("FAIL err_pc%h got v=%0b err=%b ins=%h want v=1 err=%b ins=%h", pcs[i], bus.rsp_valid, bus.rsp_err, bus.rsp_ins, errs[i], NOP_INSN);
      end
    end
    bus.req_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    rsp_t e1, e2;
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_pc = 32'h4;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready got %0b want 1", bus.req_ready); end
    e1 = model(32'h4); exp_q.push_back(e1);
    tick();
    bus.req_pc = 32'h8;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_ins !== e1.ins || bus.rsp_pc !== e1.pc || bus.rsp_err !== e1.err) begin
        errors++; $display("FAIL bp_hold%0d got rdy=%0b v=%0b ins=%h pc=%h want rdy=0 v=1 ins=%h pc=%h", c, bus.req_ready, bus.rsp_valid, bus.rsp_ins, bus.rsp_pc, e1.ins, e1.pc);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b want 1", bus.req_ready); end
    e1 = exp_q.pop_front();
    e2 = model(32'h8); exp_q.push_back(e2);
    tick();
    bus.req_valid = 1'b0;
    e2 = exp_q.pop_front();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_ins !== e2.ins || bus.rsp_pc !== e2.pc || bus.rsp_err !== e2.err) begin
      errors++; $display("FAIL bp_second got v=%0b ins=%h pc=%h want v=1 ins=%h pc=%h", bus.rsp_valid, bus.rsp_ins, bus.rsp_pc, e2.ins, e2.pc);
    end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", bus.rsp_valid); end
  endtask

  task automatic test_flush();
    rsp_t e;
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_pc = 32'hC;
    #1;
    exp_q.push_back(model(32'hC));
    tick();
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL flush_pending got %0b want 1", bus.rsp_valid); end
    bus.flush = 1'b1; bus.req_pc = 32'h8;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b want 0", bus.req_ready); end
    tick();
    bus.flush = 1'b0; bus.req_valid = 1'b0;
    e = exp_q.pop_front();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_clear got %0b want 0 (dropped pc %h)", bus.rsp_valid, e.pc); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept got %0b want 0", bus.rsp_valid); end
    bus.rsp_ready = 1'b1;
  endtask

  task automatic test_collision();
    rsp_t e;
    bus.rsp_ready = 1'b1;
    bus.prog_we = 1'b1; bus.prog_addr = 4'd5; bus.prog_data = 32'hFF80_0413;
    bus.req_valid = 1'b1; bus.req_pc = 32'h14;
    #1;
    exp_q.push_back(model(32'h14));
    tick();
    mem_m[5] = 32'hFF80_0413;
    bus.prog_we = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_ins !== 32'h0000_0033 || bus.rsp_ins !== e.ins || bus.rsp_pc !== 32'h14) begin
      errors++; $display("FAIL coll_old got v=%0b ins=%h pc=%h want v=1 ins=00000033 pc=00000014", bus.rsp_valid, bus.rsp_ins, bus.rsp_pc);
    end
    #1;
    exp_q.push_back(model(32'h14));
    tick();
    bus.req_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_ins !== 32'hFF80_0413 || bus.rsp_ins !== e.ins) begin
      errors++; $display("FAIL coll_new got v=%0b ins=%h want v=1 ins=ff800413", bus.rsp_valid, bus.rsp_ins);
    end
    tick();
  endtask

  task automatic test_random();
    logic vld_m;
    logic exp_ready;
    logic acc;
    logic wr;
    logic [ADDR_W-1:0] wa;
    logic [31:0] wd;
    rsp_t e;
    vld_m = 1'b0;
    for (int c = 0; c < 80; c++) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_pc = ($urandom_range(0, 5) == 0) ? 32'($urandom) : 32'($urandom_range(0, 15)) << 2;
      bus.rsp_ready = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) == 0);
      wa = ADDR_W'($urandom_range(0, DEPTH - 1));
      wd = 32'($urandom);
      bus.prog_we = wr; bus.prog_addr = wa; bus.prog_data = wd;
      #1;
      exp_ready = !vld_m || bus.rsp_ready;
      checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d got %0b want %0b", c, bus.req_ready, exp_ready); end
      checks++; if (bus.rsp_valid !== vld_m) begin errors++; $display("FAIL rnd_valid c%0d got %0b want %0b", c, bus.rsp_valid, vld_m); end
      if (vld_m && bus.rsp_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.rsp_ins !== e.ins || bus.rsp_pc !== e.pc || bus.rsp_err !== e.err) begin
          errors++; $display("FAIL rnd_rsp c%0d got ins=%h pc=%h err=%b want ins=%h pc=%h err=%b", c, bus.rsp_ins, bus.rsp_pc, bus.rsp_err, e.ins, e.pc, e.err);
        end
      end
      acc = bus.req_valid && exp_ready;
      if (acc) exp_q.push_back(model(bus.req_pc));
      vld_m = acc || (vld_m && !bus.rsp_ready);
      tick();
      if (wr) mem_m[wa] = wd;
    end
    bus.req_valid = 1'b0; bus.prog_we = 1'b0; bus.rsp_ready = 1'b1;
    #1;
    if (vld_m) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_ins !== e.ins || bus.rsp_pc !== e.pc || bus.rsp_err !== e.err) begin
        errors++; $display("FAIL rnd_last got v=%0b ins=%h pc=%h want v=1 ins=%h pc=%h", bus.rsp_valid, bus.rsp_ins, bus.rsp_pc, e.ins, e.pc);
      end
    end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain got v=%0b q=%0d want v=0 q=0", bus.rsp_valid, exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_load_fetch();
    test_errors();
    test_back_to_back();
    test_flush();
    test_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_fetch.md
Name: imem_fetch

Overview:
- Parametrised, writable instruction memory with a ready/valid fetch interface.
- Replaces the fixed ROM-style instruction store and sits between the PC/fetch stage and decode.
- Adds a program-load port, an optional clear-to-NOP initialisation sequence, back-pressure, flush on redirect, and error tagging for misaligned or out-of-range PCs.

Parameters:
- XLEN, 32: width of the PC and instruction words.
- DEPTH, 256: number of instruction words; must be a power of two, at least 16.
- ADDR_W, log2(DEPTH): word-index width; derived, not overridden.
- NOP_INSN, 32'h00000033: word returned on error and written during clear.
- CLEAR_ON_RESET, 1: 1 = run the INIT clear sequence after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request can be accepted.
- req_pc  in  XLEN  byte address of the instruction.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_ins  out  XLEN  instruction word.
- rsp_pc  out  XLEN  PC echoed back with the response.
- rsp_err  out  2  bit0 = misaligned, bit1 = out of range.
- flush  in  1  redirect: discard the pending response.
- prog_we  in  1  program-load write strobe.
- prog_addr  in  ADDR_W  word index to write.
- prog_data  in  XLEN  word to write.
- init_done  out  1  high in RUN state.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Reset values:
  - rsp_valid = 0, rsp_ins = NOP_INSN, rsp_pc = 0, rsp_err = 0.
  - init_done = 0 if CLEAR_ON_RESET = 1, else 1.
  - Clear counter = 0.
  - Memory contents are not reset.
- FSM states:
  - INIT: clears one word per cycle to NOP_INSN, index 0 up to DEPTH-1. req_ready = 0. prog_we is ignored. After writing index DEPTH-1, next state is RUN, so init_done rises exactly DEPTH cycles after rst deasserts.
  - RUN: normal operation. Only rst leaves RUN.
- rst asserted in any state, including mid-INIT, restarts from the reset state; the clear counter returns to 0.
- req_ready in RUN = !flush && (!rsp_valid || rsp_ready).
- Accept: req_valid && req_ready at edge N. The response registers load at edge N, so rsp_valid is high in cycle N+1. Latency is 1 cycle.
- Response content:
  - rsp_pc = req_pc.
  - err_mis = (req_pc[1:0] != 0).
  - err_oor = (req_pc[XLEN-1:ADDR_W+2] != 0).
  - If either error bit is set, rsp_ins = NOP_INSN; otherwise rsp_ins = mem[req_pc[ADDR_W+1:2]].
  - Both error bits may be set together.
- Hold: while rsp_valid && !rsp_ready, rsp_ins, rsp_pc and rsp_err stay stable and no new request is accepted.
- Retire: rsp_valid && rsp_ready with no new accept in the same cycle gives rsp_valid = 0 at the next edge. Retire plus accept in the same cycle gives back-to-back responses with full throughput.
- Flush:
  - At the edge where flush = 1, rsp_valid clears regardless of rsp_ready.
  - No request is accepted in that cycle.
  - Flush has priority over hold and accept.
  - Flush during INIT has no effect.
- Program load: a write happens in RUN when prog_we = 1: mem[prog_addr] <= prog_data.
- Same-cycle write and fetch to the same word: read-first, so the response carries the old word. The new word is visible to the next accepted request.
- Memory is a single synchronous-write array with one read port and one write port.

Decomposition:
- Shared package imem_pkg holds:
  - NOP_INSN constant.
  - rsp_err bit-position constants ERR_MIS = 0, ERR_OOR = 1.
  - FSM state enum {INIT, RUN}.
- One natural sub-module: imem_ram, a DEPTH x XLEN array with one write port and one read port, read-first.
- The FSM, handshake and error logic stay in imem_fetch.

Test Plan:
- Init sequence: CLEAR_ON_RESET = 1, DEPTH = 16. Release rst → init_done rises after exactly 16 cycles and req_ready stays 0 until then. A fetch of 0x0 then returns 0x00000033 with err = 0.
- Load and fetch: write prog_addr 1..3 with 0x00100093, 0x00200113, 0x00300193. Fetch PC 0x4, 0x8, 0xC back-to-back with rsp_ready = 1 → responses in consecutive cycles, one cycle after each accept, with matching rsp_pc.
- Errors: fetch 0x6 → err = 01, ins = NOP. Fetch 0x40 with DEPTH = 16 → err = 10. Fetch 0x42 → err = 11.
- Back-pressure: hold rsp_ready = 0 for 3 cycles with req_valid = 1 → req_ready = 0 and the response stays stable. Then rsp_ready = 1 → retire and accept happen in the same cycle.
- Flush: a response is pending and flush = 1 → rsp_valid = 0 next cycle and the concurrent request is not accepted.
- Collision and reset: write 0xFF800413 to word 5 while fetching PC 0x14 → old word returned, and the next fetch returns 0xFF800413. Assert rst mid-INIT → the clear counter restarts at 0.
